// File: rtl/dds_pkg.sv
// Shared widths, waveform codes and FSM encodings for the DDS front-panel controller.
package dds_pkg;

    localparam int FREQ_W = 12;
    localparam int WAVE_W = 2;

    localparam logic [WAVE_W-1:0] WAVE_SINE = 2'd0;
    localparam logic [WAVE_W-1:0] WAVE_SQU  = 2'd1;
    localparam logic [WAVE_W-1:0] WAVE_TRI  = 2'd2;
    localparam logic [WAVE_W-1:0] WAVE_SAW  = 2'd3;

    typedef enum logic [1:0] {
        ST_MANUAL     = 2'd0,
        ST_SWEEP_UP   = 2'd1,
        ST_SWEEP_DOWN = 2'd2
    } state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Free-running dwell counter: tick is high in the cycle the counter sits at DWELL-1 while enabled.
// Combinational tick, so the step lands on the same edge the counter wraps; clr suppresses it.
module dds_dwell_timer #(
    parameter int DWELL = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = en & ~clr & w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dds_ctrl.sv
// Front-panel controller: button pulses -> saturating freq_ctl, wave_selector and a triangular sweep.
// All outputs registered; a pulse sampled at edge k is visible after edge k, update high for one cycle.
module dds_ctrl
    import dds_pkg::*;
#(
    parameter logic [FREQ_W-1:0] FREQ_MIN = 12'd1,
    parameter logic [FREQ_W-1:0] FREQ_MAX = 12'd1000,
    parameter logic [FREQ_W-1:0] STEP     = 12'd10,
    parameter int                DWELL    = 10000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_wave,
    input  logic              btn_sweep,
    output logic [FREQ_W-1:0] freq_ctl,
    output logic [WAVE_W-1:0] wave_selector,
    output logic              sweeping,
    output logic              update
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FREQ_W-1:0] r_freq;
    logic [FREQ_W-1:0] w_freq_nxt;
    logic [WAVE_W-1:0] r_wave;
    logic [WAVE_W-1:0] w_wave_nxt;
    logic              r_sweeping;
    logic              r_update;
    logic              w_tick;
    logic              w_in_sweep;

    // One extra bit so freq+STEP can never wrap before the saturation compare.
    logic [FREQ_W:0]   w_freq13;
    logic [FREQ_W:0]   w_up_sum;
    logic [FREQ_W:0]   w_max13;
    logic [FREQ_W:0]   w_floor13;

    assign w_freq13   = {1'b0, r_freq};
    assign w_up_sum   = w_freq13 + {1'b0, STEP};
    assign w_max13    = {1'b0, FREQ_MAX};
    assign w_floor13  = {1'b0, FREQ_MIN} + {1'b0, STEP};
    assign w_in_sweep = (r_state != ST_MANUAL);

    dds_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_in_sweep),
        .clr   (btn_sweep),
        .tick  (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_freq_nxt  = r_freq;
        w_wave_nxt  = btn_wave ? r_wave + WAVE_W'(1) : r_wave;
        case (r_state)
            ST_MANUAL: begin
                if (btn_sweep) begin
                    w_state_nxt = ST_SWEEP_UP;
                end else if (btn_up && !btn_down) begin
                    w_freq_nxt = (w_up_sum >= w_max13) ? FREQ_MAX : w_up_sum[FREQ_W-1:0];
                end else if (btn_down && !btn_up) begin
                    w_freq_nxt = (w_freq13 >= w_floor13) ? r_freq - STEP : FREQ_MIN;
                end
            end
            ST_SWEEP_UP: begin
                if (btn_sweep) begin
                    w_state_nxt = ST_MANUAL;
                end else if (w_tick) begin
                    if (w_up_sum >= w_max13) begin
                        w_freq_nxt  = FREQ_MAX;
                        w_state_nxt = ST_SWEEP_DOWN;
                    end else begin
                        w_freq_nxt = w_up_sum[FREQ_W-1:0];
                    end
                end
            end
            ST_SWEEP_DOWN: begin
                if (btn_sweep) begin
                    w_state_nxt = ST_MANUAL;
                end else if (w_tick) begin
                    if (w_freq13 <= w_floor13) begin
                        w_freq_nxt  = FREQ_MIN;
                        w_state_nxt = ST_SWEEP_UP;
                    end else begin
                        w_freq_nxt = r_freq - STEP;
                    end
                end
            end
            default: w_state_nxt = ST_MANUAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_MANUAL;
            r_freq     <= FREQ_MIN;
            r_wave     <= WAVE_SINE;
            r_sweeping <= 1'b0;
            r_update   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_freq     <= w_freq_nxt;
            r_wave     <= w_wave_nxt;
            r_sweeping <= (w_state_nxt != ST_MANUAL);
            r_update   <= (w_freq_nxt != r_freq) || (w_wave_nxt != r_wave);
        end
    end

    assign freq_ctl      = r_freq;
    assign wave_selector = r_wave;
    assign sweeping      = r_sweeping;
    assign update        = r_update;

endmodule

// File: tb/tb_dds_ctrl.sv
// Bench for dds_ctrl with MIN=1, MAX=100, STEP=10, DWELL=4: vector table plus sweep-floor and reset sequences.
module tb_dds_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_wave = 1'b0;
    logic        btn_sweep = 1'b0;
    logic [11:0] freq_ctl;
    logic [1:0]  wave_selector;
    logic        sweeping;
    logic        update;

    typedef struct {
        logic up;
        logic dn;
        logic wv;
        logic sw;
        int   f;
        int   w;
        int   s;
        int   u;
    } vec_t;

    typedef struct {
        int f;
        int w;
        int s;
        int u;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   nvec  = 0;

    always #5 clk = ~clk;

    dds_ctrl #(
        .FREQ_MIN (12'd1),
        .FREQ_MAX (12'd100),
        .STEP     (12'd10),
        .DWELL    (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_wave      (btn_wave),
        .btn_sweep     (btn_sweep),
        .freq_ctl      (freq_ctl),
        .wave_selector (wave_selector),
        .sweeping      (sweeping),
        .update        (update)
    );

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    task automatic add(input logic u, input logic d, input logic w, input logic s,
                       input int f, input int wv, input int sw, input int up);
        vec_t v;
        v.up = u; v.dn = d; v.wv = w; v.sw = s;
        v.f = f; v.w = wv; v.s = sw; v.u = up;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        btn_up    = v.up;
        btn_down  = v.dn;
        btn_wave  = v.wv;
        btn_sweep = v.sw;
        sb.push_back('{v.f, v.w, v.s, v.u});
        @(posedge clk);
        #1;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_wave  = 1'b0;
        btn_sweep = 1'b0;
        e = sb.pop_front();
        check($sformatf("vec%0d freq_ctl", nvec), int'(freq_ctl), e.f);
        check($sformatf("vec%0d wave_selector", nvec), int'(wave_selector), e.w);
        check($sformatf("vec%0d sweeping", nvec), int'(sweeping), e.s);
        check($sformatf("vec%0d update", nvec), int'(update), e.u);
        nvec++;
    endtask

    initial begin
        vec_t v;
        int   floor_seq[13] = '{90, 100, 90, 80, 70, 60, 50, 40, 30, 20, 10, 1, 11};
        int   prev;

        // Manual saturation up and down.
        for (int i = 0; i < 12; i++)
            add(1, 0, 0, 0, (i < 9) ? 11 + 10 * i : 100, 0, 0, (i <= 9) ? 1 : 0);
        for (int i = 0; i < 12; i++)
            add(0, 1, 0, 0, (i < 9) ? 90 - 10 * i : 1, 0, 0, (i <= 9) ? 1 : 0);
        for (int i = 0; i < 5; i++)
            add(1, 0, 0, 0, 11 + 10 * i, 0, 0, 1);
        add(1, 1, 0, 0, 51, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 1, 0, 51, (i + 1) % 4, 0, 1);
        for (int i = 0; i < 3; i++)
            add(1, 0, 0, 0, 61 + 10 * i, 1, 0, 1);
        // Sweep from 81, wave press mid-sweep, stop on a tick edge.
        add(0, 0, 0, 1, 81, 1, 1, 0);
        for (int j = 1; j < 20; j++)
            add(1, 1, (j == 13), 0,
                (j < 4) ? 81 : (j < 8) ? 91 : (j < 12) ? 100 : (j < 16) ? 90 : 80,
                (j >= 13) ? 2 : 1, 1, ((j % 4) == 0 || j == 13) ? 1 : 0);
        add(0, 0, 0, 1, 80, 2, 0, 0);
        for (int j = 0; j < 3; j++)
            add(0, 0, 0, 0, 80, 2, 0, 0);

        // Asynchronous reset state.
        #12;
        check("reset freq_ctl", int'(freq_ctl), 1);
        check("reset wave_selector", int'(wave_selector), 0);
        check("reset sweeping", int'(sweeping), 0);
        check("reset update", int'(update), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Full sweep from 80 through the ceiling and floor back to 11.
        v = '{1'b0, 1'b0, 1'b0, 1'b1, 80, 2, 1, 0};
        apply(v);
        prev = 80;
        for (int k = 0; k < 13; k++) begin
            for (int c = 0; c < 3; c++) begin
                v = '{1'b0, 1'b0, 1'b0, 1'b0, prev, 2, 1, 0};
                apply(v);
            end
            v = '{1'b0, 1'b0, 1'b0, 1'b0, floor_seq[k], 2, 1, 1};
            apply(v);
            prev = floor_seq[k];
        end
        v = '{1'b0, 1'b0, 1'b0, 1'b0, 11, 2, 1, 0};
        apply(v);
        apply(v);

        // Reset mid-sweep between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset freq_ctl", int'(freq_ctl), 1);
        check("midreset wave_selector", int'(wave_selector), 0);
        check("midreset sweeping", int'(sweeping), 0);
        check("midreset update", int'(update), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            v = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0};
            apply(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_ctrl.md
# dds_ctrl

Front-panel controller for the DDS waveform generator. It turns single-cycle button pulses into the `freq_ctl` and `wave_selector` settings consumed by the waveform output stage. It supports manual frequency stepping and an automatic triangular frequency sweep. It runs on the same 10 kHz clock as the waveform datapath and feeds it directly.

## Interface
Parameters:
- `FREQ_MIN`, default 12'd1: lowest legal `freq_ctl`.
- `FREQ_MAX`, default 12'd1000: highest legal `freq_ctl`. Must be greater than `FREQ_MIN`.
- `STEP`, default 12'd10: frequency increment per button press or sweep step. Must be ≥1.
- `DWELL`, default 10000: clock cycles between sweep steps. Must be ≥1. The default gives 1 s at 10 kHz.

Ports:
- `clk` in 1: system clock (10 kHz).
- `rst_n` in 1: asynchronous active-low reset.
- `btn_up` in 1: one-cycle pulse, already debounced and synchronized; requests a frequency increase.
- `btn_down` in 1: one-cycle pulse; requests a frequency decrease.
- `btn_wave` in 1: one-cycle pulse; selects the next waveform.
- `btn_sweep` in 1: one-cycle pulse; toggles sweep mode.
- `freq_ctl` out 12: phase-increment control word to the waveform stage.
- `wave_selector` out 2: waveform select: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- `sweeping` out 1: high while in a sweep state.
- `update` out 1: one-cycle pulse on any change of `freq_ctl` or `wave_selector`.

## Operation
- Reset values: `freq_ctl`=`FREQ_MIN`, `wave_selector`=0, `sweeping`=0, `update`=0, state MANUAL, dwell counter 0.
- FSM states: MANUAL, SWEEP_UP, SWEEP_DOWN.
- **MANUAL state:**
  - `btn_up`: `freq_ctl` = min(`freq_ctl`+`STEP`, `FREQ_MAX`).
  - `btn_down`: `freq_ctl` = max(`freq_ctl`−`STEP`, `FREQ_MIN`).
  - `btn_up` and `btn_down` in the same cycle: both ignored.
  - Press while already at the limit: no change and no `update` pulse.
- **Entering and leaving sweep:**
  - `btn_sweep` in MANUAL: go to SWEEP_UP and clear the dwell counter. `freq_ctl` is unchanged.
  - `btn_sweep` in either sweep state: go to MANUAL. `freq_ctl` holds its current value. The dwell counter clears.
- **Sweep states:**
  - `btn_up` and `btn_down` are ignored.
  - The dwell counter increments every cycle. At `DWELL`−1 it wraps to 0 and performs one step.
  - SWEEP_UP step: if `freq_ctl`+`STEP` ≥ `FREQ_MAX`, load `FREQ_MAX` and go to SWEEP_DOWN. Otherwise add `STEP`.
  - SWEEP_DOWN step: if `freq_ctl` ≤ `FREQ_MIN`+`STEP`, load `FREQ_MIN` and go to SWEEP_UP. Otherwise subtract `STEP`.
- **`btn_wave`:** works in any state; `wave_selector` increments modulo 4 (3→0).
- **Simultaneous events:**
  - `btn_wave` combines freely with any other event in the same cycle.
  - `btn_sweep` in the same cycle as a dwell step: the toggle wins and the step is discarded.
- **Arithmetic:** compute with 13-bit intermediates so `freq_ctl`+`STEP` cannot wrap. `freq_ctl` never leaves [`FREQ_MIN`, `FREQ_MAX`].
- **Reset mid-sweep:** reset returns immediately to the reset values. No partial step is retained.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- A button pulse sampled at rising edge k changes the outputs at edge k. `update` is high for the one cycle after edge k.
- After `btn_sweep` enters sweep at edge k, the first step occurs at edge k+`DWELL`. Subsequent steps follow every `DWELL` cycles.
- `sweeping` changes in the same cycle as the state register.
- Reset assertion is asynchronous. Reset release is used synchronously: the first action can occur at the first edge after `rst_n` rises.

## Structure
- Shared package `dds_pkg` holds:
  - `FREQ_W`=12 and `WAVE_W`=2.
  - Waveform codes `WAVE_SINE`/`WAVE_SQU`/`WAVE_TRI`/`WAVE_SAW` = 0..3.
  - FSM state encodings.
- One sub-module, `dds_dwell_timer`: parameterized by `DWELL`, with inputs `clk`/`rst_n`/`en`/`clr` and a one-cycle `tick` output.
- The FSM and saturating arithmetic stay in `dds_ctrl`.

## Test plan
All scenarios use `FREQ_MIN`=1, `FREQ_MAX`=100, `STEP`=10, `DWELL`=4.
- **Reset:** drive `rst_n`=0 mid-operation → `freq_ctl`=1, `wave_selector`=0, `sweeping`=0 at once, without waiting for a clock.
- **Manual saturation:**
  - 12× `btn_up` → `freq_ctl` goes 11, 21 … 91, 100, then stays 100. `update` pulses 10 times.
  - 12× `btn_down` from 100 → values 90 … 10, then 1. No `update` pulse at 1.
- **Simultaneous up/down:** `btn_up` and `btn_down` in the same cycle at `freq_ctl`=51 → stays 51, no `update`.
- **Wave select:** 5× `btn_wave` → `wave_selector` 1, 2, 3, 0, 1. A `btn_wave` during sweep also advances it.
- **Sweep:** `btn_sweep` at `freq_ctl`=81 →
  - Steps every 4 cycles: 91, 100 (state becomes SWEEP_DOWN), 90, 80 ….
  - `btn_sweep` coinciding with a step tick → freeze, no step, `sweeping`=0.
- **Sweep floor:** sweep down from 11 → next step loads 1 and the state becomes SWEEP_UP. The following step gives 11.
